// File: rtl/life_row_stepper_if.sv
// Write port toward the display memory: valid/ready handshake carrying one cell per transfer.
// The stepper drives the master side; the memory (or bench) drives wr_ready.
interface life_row_stepper_if #(
  parameter int AW = 10
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_ready;

  modport master (output wr_en, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/life_row_stepper.sv
// One-dimensional cellular automaton row: seeds or advances a CELLS-bit row by one
// Wolfram-rule generation, streaming each new cell to display memory; all state moves on the falling edge.
module life_row_stepper #(
  parameter int CELLS = 640,
  parameter int AW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed_load,
  input  logic                  seed_bit,
  input  logic                  step,
  input  logic [7:0]            rule,
  input  logic [2:0]            fg_color,
  life_row_stepper_if.master    wr,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           generation
);

  typedef enum logic [1:0] {IDLE, SEED, STEP, DONE} state_t;
  localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

  state_t           state_q, state_d;
  logic [CELLS-1:0] cells_q, cells_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [7:0]       rule_q, rule_d;
  logic [2:0]       color_q, color_d;
  logic [15:0]      gen_q, gen_d;
  logic             left_q, left_d;
  logic             first_q, first_d;

  logic          accept;
  logic          xfer;
  logic          last;
  logic [AW-1:0] addr_nx;
  logic          cur_c;
  logic          cur_r;
  logic          new_bit;

  assign accept  = (state_q == IDLE) && (seed_load || step);
  assign xfer    = wr.wr_en && wr.wr_ready;
  assign last    = (addr_q == LAST);
  assign addr_nx = addr_q + 1'b1;
  assign cur_c   = cells_q[addr_q];
  // Cell 0 has already been overwritten by the time the last cell is computed.
  assign cur_r   = last ? first_q : cells_q[addr_nx];
  assign new_bit = (state_q == SEED) ? seed_bit : rule_q[{left_q, cur_c, cur_r}];

  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (seed_load) state_d = SEED;
                  else if (step) state_d = STEP;
      SEED, STEP: if (xfer && last) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs are gated by rst so they read zero for the whole reset window.
  always_comb begin
    busy        = rst && (state_q != IDLE);
    done        = rst && (state_q == DONE);
    wr.wr_en    = rst && ((state_q == SEED) || (state_q == STEP));
    wr.wr_addr  = rst ? addr_q : '0;
    wr.wr_data  = wr.wr_en ? {new_bit, new_bit ? color_q : 3'b000} : 4'b0000;
    generation  = rst ? gen_q : 16'd0;
  end

  always_comb begin
    cells_d = cells_q;
    addr_d  = addr_q;
    rule_d  = rule_q;
    color_d = color_q;
    gen_d   = gen_q;
    left_d  = left_q;
    first_d = first_q;
    if (accept) begin
      addr_d  = '0;
      rule_d  = rule;
      color_d = fg_color;
      left_d  = cells_q[CELLS-1];
      first_d = cells_q[0];
    end
    if (xfer) begin
      cells_d[addr_q] = new_bit;
      left_d          = cur_c;
      addr_d          = last ? '0 : addr_nx;
      if (last) gen_d = (state_q == STEP) ? gen_q + 16'd1 : 16'd0;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      cells_q <= '0;
      addr_q  <= '0;
      rule_q  <= '0;
      color_q <= '0;
      gen_q   <= '0;
      left_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      cells_q <= cells_d;
      addr_q  <= addr_d;
      rule_q  <= rule_d;
      color_q <= color_d;
      gen_q   <= gen_d;
      left_q  <= left_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_life_row_stepper.sv
// Randomised scoreboard bench for life_row_stepper: inputs change just after the falling
// edge, outputs are observed on the rising edge.
module tb_life_row_stepper;
  localparam int CELLS = 640;
  localparam int AW    = 10;

  logic       clk;
  logic       rst;
  logic       seed_load;
  logic       seed_bit;
  logic       step;
  logic [7:0] rule;
  logic [2:0] fg_color;
  logic       busy;
  logic       done;
  logic [15:0] generation;

  life_row_stepper_if #(.AW(AW)) wr_if ();

  life_row_stepper #(.CELLS(CELLS), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed_bit   (seed_bit),
    .step       (step),
    .rule       (rule),
    .fg_color   (fg_color),
    .wr         (wr_if),
    .busy       (busy),
    .done       (done),
    .generation (generation)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int       addr;
    logic [3:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         exp_gen[$];
  bit         model[CELLS];
  int         gen_m;
  logic [CELLS-1:0] seed_vec;

  int n_cmp;
  int n_bad;
  int done_cnt;
  int busy_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: every transfer must match the head of the expectation queue.
  logic        hold_vld;
  logic [AW-1:0] hold_addr;
  logic [3:0]  hold_data;
  initial hold_vld = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (wr_if.wr_en && wr_if.wr_ready) begin
        if (exp_q.size() == 0) begin
          report($sformatf("unexpected_write addr=%0d", wr_if.wr_addr));
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_if.wr_addr), 32'(e.addr));
          chk($sformatf("wr_data@%0d", e.addr), 32'(wr_if.wr_data), 32'(e.data));
        end
      end
      if (hold_vld) begin
        chk("stall_en", 32'(wr_if.wr_en), 32'd1);
        chk("stall_addr", 32'(wr_if.wr_addr), 32'(hold_addr));
        chk("stall_data", 32'(wr_if.wr_data), 32'(hold_data));
      end
      hold_vld  = wr_if.wr_en && !wr_if.wr_ready;
      hold_addr = wr_if.wr_addr;
      hold_data = wr_if.wr_data;
      if (done) begin
        done_cnt++;
        if (exp_gen.size() == 0) report("unexpected_done");
        else chk("generation", 32'(generation), 32'(exp_gen.pop_front()));
      end
      if (busy) busy_cycles++;
    end else begin
      hold_vld = 1'b0;
    end
  end

  task automatic expect_seed(input logic [2:0] col);
    for (int i = 0; i < CELLS; i++) begin
      wr_t e;
      model[i] = seed_vec[i];
      e.addr = i;
      e.data = {seed_vec[i], seed_vec[i] ? col : 3'b000};
      exp_q.push_back(e);
    end
    gen_m = 0;
    exp_gen.push_back(0);
  endtask

  task automatic expect_step(input logic [7:0] r, input logic [2:0] col, input bit with_done);
    bit nxt[CELLS];
    for (int i = 0; i < CELLS; i++) begin
      int l, c, rr, idx;
      wr_t e;
      l   = model[(i + CELLS - 1) % CELLS];
      c   = model[i];
      rr  = model[(i + 1) % CELLS];
      idx = l * 4 + c * 2 + rr;
      nxt[i] = (r >> idx) & 1;
      e.addr = i;
      e.data = {nxt[i], nxt[i] ? col : 3'b000};
      exp_q.push_back(e);
    end
    model = nxt;
    if (with_done) begin
      gen_m = (gen_m + 1) % 65536;
      exp_gen.push_back(gen_m);
    end
  endtask

  task automatic run_pass(input bit is_seed, input logic [7:0] r, input logic [2:0] col,
                          input bit rnd, input int inject_at);
    int cyc;
    int d0;
    if (is_seed) expect_seed(col);
    else expect_step(r, col, 1'b1);
    @(negedge clk); #1;
    busy_cycles = 0;
    d0 = done_cnt;
    rst = 1'b1;
    seed_load = is_seed;
    step = !is_seed;
    rule = r;
    fg_color = col;
    wr_if.wr_ready = 1'b1;
    @(negedge clk); #1;
    seed_load = 1'b0;
    step = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_en", 32'(wr_if.wr_en), 32'd1);
    chk("accept_addr", 32'(wr_if.wr_addr), 32'd0);
    cyc = 0;
    while (done_cnt == d0 && cyc < 4000) begin
      wr_if.wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      seed_bit = seed_vec[wr_if.wr_addr];
      step = (cyc == inject_at);
      @(negedge clk); #1;
      cyc++;
    end
    step = 1'b0;
    if (cyc >= 4000) report("timeout waiting for done");
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    if (!rnd) chk("busy_cycles", 32'(busy_cycles), 32'(CELLS + 1));
    @(negedge clk); #1;
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic single_cell(input int pos);
    seed_vec = '0;
    seed_vec[pos] = 1'b1;
  endtask

  initial begin
    int d0;
    int cyc;
    n_cmp = 0; n_bad = 0; done_cnt = 0; busy_cycles = 0; gen_m = 0;
    for (int i = 0; i < CELLS; i++) model[i] = 1'b0;
    rst = 1'b0; seed_load = 1'b0; seed_bit = 1'b0; step = 1'b1;
    rule = 8'h01; fg_color = 3'b010; wr_if.wr_ready = 1'b1;
    seed_vec = '0;

    // Reset window with a pending step: everything quiet.
    repeat (2) begin
      @(posedge clk);
      chk("rst_wr_en", 32'(wr_if.wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_gen", 32'(generation), 32'd0);
    end
    // Cleared row under rule 1 becomes all live; accepted on first rst=1 edge.
    run_pass(1'b0, 8'h01, 3'b010, 1'b0, -1);

    seed_vec = '1;
    run_pass(1'b1, 8'h00, 3'b101, 1'b0, -1);

    single_cell(320);
    run_pass(1'b1, 8'h00, 3'b111, 1'b0, 50);
    run_pass(1'b0, 8'h5A, 3'b110, 1'b0, -1);

    single_cell(0);
    run_pass(1'b1, 8'h00, 3'b001, 1'b0, -1);
    run_pass(1'b0, 8'h5A, 3'b011, 1'b0, -1);

    single_cell(320);
    run_pass(1'b1, 8'h00, 3'b100, 1'b1, -1);
    run_pass(1'b0, 8'h5A, 3'b101, 1'b1, -1);

    for (int i = 0; i < CELLS; i++) seed_vec[i] = 1'($urandom_range(0, 1));
    run_pass(1'b1, 8'h00, 3'($urandom_range(0, 7)), 1'b1, -1);
    run_pass(1'b0, 8'($urandom), 3'($urandom_range(0, 7)), 1'b1, -1);
    run_pass(1'b0, 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, -1);

    // Abort a step pass at address 100.
    expect_step(8'h01, 3'b011, 1'b0);
    @(negedge clk); #1;
    step = 1'b1; rule = 8'h01; fg_color = 3'b011; wr_if.wr_ready = 1'b1;
    @(negedge clk); #1;
    step = 1'b0;
    cyc = 0;
    while (wr_if.wr_addr != AW'(100) && cyc < 1000) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (cyc >= 1000) report("timeout waiting for addr 100");
    d0 = done_cnt;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_wr_en", 32'(wr_if.wr_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_gen", 32'(generation), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    exp_q.delete();
    for (int i = 0; i < CELLS; i++) model[i] = 1'b0;
    gen_m = 0;
    // Cleared row under rule 1 must come back all live with generation 1.
    run_pass(1'b0, 8'h01, 3'b110, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
